// File: rtl/dsp_buf_pkg.sv
// Shared constants for the chunked sample buffer: default sizes used by the
// writer, FIFO and reader stages, plus the writer state encoding.
package dsp_buf_pkg;

  localparam int SAMPLE_SIZE_DEF  = 24;
  localparam int IO_BUFF_SIZE_DEF = 64;
  localparam int FIFO_DEPTH_DEF   = 16;

  typedef enum logic [2:0] {
    WR_IDLE   = 3'd0,
    WR_FILL   = 3'd1,
    WR_PAD    = 3'd2,
    WR_LAST   = 3'd3,
    WR_COMMIT = 3'd4
  } wr_state_e;

endpackage

// File: rtl/chunk_credit_counter.sv
// Saturating count of occupied chunk slots, incremented on commit and
// decremented on consumption, with a sticky underflow flag.
module chunk_credit_counter
  import dsp_buf_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_BITS   = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                dec,
  output logic [CNT_BITS-1:0] count,
  output logic                underflow_err
);

  localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(FIFO_DEPTH);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count         <= '0;
      underflow_err <= 1'b0;
    end else if (inc && !dec) begin
      if (count != FULL) count <= count + CNT_BITS'(1);
    end else if (dec && !inc) begin
      if (count == '0) underflow_err <= 1'b1;
      else             count         <= count - CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/chunk_writer.sv
// Packs a valid/ready sample stream into IO_BUFF_SIZE-sample chunks for the
// chunked FIFO, zero-padding on flush and stalling while the FIFO is full.
module chunk_writer
  import dsp_buf_pkg::*;
#(
  parameter int SAMPLE_SIZE      = SAMPLE_SIZE_DEF,
  parameter int IO_BUFF_SIZE     = IO_BUFF_SIZE_DEF,
  parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE),
  parameter int FIFO_DEPTH       = FIFO_DEPTH_DEF,
  parameter int CNT_BITS         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [SAMPLE_SIZE-1:0]      s_sample,
  input  logic                        flush,
  input  logic                        read_done,
  output logic                        fill,
  output logic [IO_BUFF_PTR_BITS-1:0] write_ptr,
  output logic [SAMPLE_SIZE-1:0]      write_sample,
  output logic                        fill_done,
  output logic [CNT_BITS-1:0]         chunks_used,
  output logic                        underflow_err
);

  localparam logic [IO_BUFF_PTR_BITS-1:0] LAST_IDX = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);
  localparam logic [CNT_BITS-1:0]         FULL     = CNT_BITS'(FIFO_DEPTH);

  wr_state_e                   state, state_n;
  logic [IO_BUFF_PTR_BITS-1:0] wr_idx, wr_idx_n;
  logic [IO_BUFF_PTR_BITS-1:0] write_ptr_n;
  logic [SAMPLE_SIZE-1:0]      write_sample_n;
  logic                        fill_n, fill_done_n;
  logic                        accept;

  assign s_ready = (state == WR_FILL);
  assign accept  = s_valid && s_ready;

  // NOTE: every signal driven here is given a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n        = state;
    wr_idx_n       = wr_idx;
    fill_n         = 1'b0;
    fill_done_n    = 1'b0;
    write_ptr_n    = write_ptr;
    write_sample_n = write_sample;
    case (state)
      WR_IDLE: begin
        wr_idx_n = '0;
        if (chunks_used < FULL) state_n = WR_FILL;
      end
      WR_FILL: begin
        if (accept) begin
          fill_n         = 1'b1;
          write_ptr_n    = wr_idx;
          write_sample_n = s_sample;
          wr_idx_n       = wr_idx + IO_BUFF_PTR_BITS'(1);
          if (wr_idx == LAST_IDX) state_n = WR_LAST;
          else if (flush)         state_n = WR_PAD;
        end else if (flush && wr_idx != '0) begin
          state_n = WR_PAD;
        end
      end
      WR_PAD: begin
        fill_n         = 1'b1;
        write_ptr_n    = wr_idx;
        write_sample_n = '0;
        wr_idx_n       = wr_idx + IO_BUFF_PTR_BITS'(1);
        if (wr_idx == LAST_IDX) state_n = WR_LAST;
      end
      WR_LAST: begin
        // Final write is on the bus now; announce the chunk one cycle later.
        fill_done_n = 1'b1;
        state_n     = WR_COMMIT;
      end
      WR_COMMIT: state_n = WR_IDLE;
      default:   state_n = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= WR_IDLE;
      wr_idx       <= '0;
      fill         <= 1'b0;
      fill_done    <= 1'b0;
      write_ptr    <= '0;
      write_sample <= '0;
    end else begin
      state        <= state_n;
      wr_idx       <= wr_idx_n;
      fill         <= fill_n;
      fill_done    <= fill_done_n;
      write_ptr    <= write_ptr_n;
      write_sample <= write_sample_n;
    end
  end

  chunk_credit_counter #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_BITS   (CNT_BITS)
  ) u_credit (
    .clk           (clk),
    .rst           (rst),
    .inc           (fill_done),
    .dec           (read_done),
    .count         (chunks_used),
    .underflow_err (underflow_err)
  );

endmodule

// File: tb/tb_chunk_writer.sv
// Self-checking bench for chunk_writer with 4-sample chunks and a 2-slot FIFO:
// a cycle table for the directed flow plus a write/commit scoreboard.
module tb_chunk_writer;

  localparam int SW = 24;
  localparam int NB = 4;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [SW-1:0] s_sample = '0;
  logic          flush = 1'b0;
  logic          read_done = 1'b0;
  logic          fill;
  logic [1:0]    write_ptr;
  logic [SW-1:0] write_sample;
  logic          fill_done;
  logic [1:0]    chunks_used;
  logic          underflow_err;

  chunk_writer #(.SAMPLE_SIZE(SW), .IO_BUFF_SIZE(NB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sample(s_sample),
    .flush(flush), .read_done(read_done), .fill(fill), .write_ptr(write_ptr),
    .write_sample(write_sample), .fill_done(fill_done), .chunks_used(chunks_used),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input bit ok, input string detail);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    int          due;
    logic [1:0]  ptr;
    logic [SW-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   cyc = 0;
  bit   in_reset = 1'b1;
  int   model_idx = 0;
  int   exp_used = 0;
  bit   exp_err = 1'b0;
  bit   expect_done = 1'b0;
  int   commits = 0;
  int   max_used = 0;

  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (in_reset) begin
      check("reset_outputs",
            fill === 1'b0 && fill_done === 1'b0 && write_ptr === 2'd0 && write_sample === '0 &&
            s_ready === 1'b0 && chunks_used === 2'd0 && underflow_err === 1'b0,
            $sformatf("got fill=%b done=%b ptr=%0d data=%0h ready=%b used=%0d err=%b, need all 0",
                      fill, fill_done, write_ptr, write_sample, s_ready, chunks_used, underflow_err));
      exp_q.delete();
      model_idx = 0; exp_used = 0; exp_err = 1'b0; expect_done = 1'b0;
    end else begin
      if (fill_done === 1'b1 || expect_done)
        check("fill_done_timing", fill_done === expect_done,
              $sformatf("cycle %0d got fill_done=%b need %b", cyc, fill_done, expect_done));
      if (fill_done === 1'b1) begin
        check("done_without_fill", fill === 1'b0, $sformatf("got fill=%b need 0", fill));
        commits++;
      end
      expect_done = 1'b0;
      if (fill === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1'b0,
                $sformatf("cycle %0d got write ptr=%0d data=%0h, need none", cyc, write_ptr, write_sample));
        end else begin
          e = exp_q.pop_front();
          check("write", write_ptr === e.ptr && write_sample === e.data && cyc == e.due,
                $sformatf("got ptr=%0d data=%0h cycle=%0d need ptr=%0d data=%0h cycle=%0d",
                          write_ptr, write_sample, cyc, e.ptr, e.data, e.due));
          if (e.ptr == 2'(NB - 1)) expect_done = 1'b1;
        end
      end
      check("chunks_used", chunks_used === 2'(exp_used),
            $sformatf("cycle %0d got %0d need %0d", cyc, chunks_used, exp_used));
      check("underflow_err", underflow_err === exp_err,
            $sformatf("cycle %0d got %b need %b", cyc, underflow_err, exp_err));
      if (int'(chunks_used) > max_used) max_used = int'(chunks_used);
    end
    // Predict the effect of the upcoming edge.
    if (rst === 1'b1) begin
      if (fill_done === 1'b1 && !read_done) begin
        if (exp_used < FD) exp_used++;
      end else if (fill_done !== 1'b1 && read_done) begin
        if (exp_used == 0) exp_err = 1'b1;
        else               exp_used--;
      end
      if (s_ready === 1'b1) begin
        if (s_valid) begin
          exp_q.push_back('{due: cyc + 1, ptr: 2'(model_idx), data: s_sample});
          model_idx = (model_idx + 1) % NB;
        end
        if (flush && model_idx != 0) begin
          for (int i = model_idx; i < NB; i++)
            exp_q.push_back('{due: cyc + 2 + (i - model_idx), ptr: 2'(i), data: '0});
          model_idx = 0;
        end
      end
    end
    in_reset = (rst !== 1'b1);
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    bit          v;
    logic [SW-1:0] d;
    bit          f;
    bit          r;
    bit          ready;
    logic [1:0]  used;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input bit v, input int d, input bit f, input bit r, input bit ready, input int used);
    tbl.push_back('{v: v, d: SW'(d), f: f, r: r, ready: ready, used: 2'(used)});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    s_valid = 1'b0; flush = 1'b0; read_done = 1'b0;
  endtask

  task automatic send(input logic [SW-1:0] d);
    int  n = 0;
    bit  done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_sample = d; flush = 1'b0; read_done = 1'b0;
      @(negedge clk);
      if (s_ready === 1'b1) done = 1'b1;
      else if (++n > 50) begin
        check("send_timeout", 1'b0, $sformatf("sample %0h never accepted within 50 cycles", d));
        done = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0; flush = 1'b0; read_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int base;
    int n;
    bit seen;

    // Directed flow: full chunk, flush-padded chunk, back-pressure, idle flush.
    //   v  d  f  r  ready used
    row(1, 1, 0, 0, 1, 0);
    row(1, 2, 0, 0, 1, 0);
    row(1, 3, 0, 0, 1, 0);
    row(1, 4, 0, 0, 1, 0);
    row(0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 1);
    row(1, 7, 0, 0, 1, 1);
    row(1, 8, 0, 0, 1, 1);
    row(0, 0, 1, 0, 1, 1);
    row(0, 0, 0, 0, 0, 1);
    row(0, 0, 0, 0, 0, 1);
    row(0, 0, 0, 0, 0, 1);
    row(0, 0, 0, 0, 0, 1);
    row(0, 0, 0, 0, 0, 2);
    row(0, 0, 0, 0, 0, 2);
    row(0, 0, 0, 1, 0, 2);
    row(0, 0, 0, 0, 0, 1);
    row(0, 0, 0, 0, 1, 1);
    row(0, 0, 1, 0, 1, 1);
    row(0, 0, 0, 0, 1, 1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      s_valid = tbl[i].v; s_sample = tbl[i].d; flush = tbl[i].f; read_done = tbl[i].r;
      @(negedge clk);
      check($sformatf("table_row%0d", i),
            s_ready === tbl[i].ready && chunks_used === tbl[i].used,
            $sformatf("got ready=%b used=%0d need ready=%b used=%0d",
                      s_ready, chunks_used, tbl[i].ready, tbl[i].used));
    end
    idle();

    // Reset after 2 of 4 samples; the partial chunk must vanish.
    send(24'h21);
    send(24'h22);
    do_reset();
    send(24'h31); send(24'h32); send(24'h33); send(24'h34);
    repeat (4) idle();

    // Continuous stream into an empty FIFO: only two chunks fit.
    do_reset();
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      s_valid = (acc < 12); s_sample = SW'(100 + acc);
      @(negedge clk);
      if (s_valid && s_ready === 1'b1) acc++;
    end
    check("accepted_when_full", acc == 8, $sformatf("got %0d samples accepted need 8", acc));
    check("used_when_full", chunks_used === 2'd2, $sformatf("got %0d need 2", chunks_used));
    check("ready_when_full", s_ready === 1'b0, $sformatf("got %b need 0", s_ready));
    @(posedge clk); #1;
    s_valid = 1'b0; read_done = 1'b1;
    @(posedge clk); #1;
    read_done = 1'b0;
    @(negedge clk);
    check("used_after_read", chunks_used === 2'd1, $sformatf("got %0d need 1", chunks_used));
    seen = (s_ready === 1'b1);
    @(negedge clk);
    seen = seen || (s_ready === 1'b1);
    check("ready_after_read", seen, "s_ready did not rise within 2 cycles of read_done");

    // read_done coinciding with fill_done at chunks_used==1.
    send(24'h41); send(24'h42); send(24'h43); send(24'h44);
    idle();
    @(posedge clk); #1;
    read_done = 1'b1;
    @(negedge clk);
    check("coincide_setup", fill_done === 1'b1, $sformatf("got fill_done=%b need 1", fill_done));
    idle();
    @(negedge clk);
    check("used_coincide", chunks_used === 2'd1, $sformatf("got %0d need 1", chunks_used));

    // Drain to zero, then underflow.
    @(posedge clk); #1 read_done = 1'b1;
    @(posedge clk); #1 read_done = 1'b1;
    idle();
    @(negedge clk);
    check("used_underflow", chunks_used === 2'd0, $sformatf("got %0d need 0", chunks_used));
    check("underflow_set", underflow_err === 1'b1, $sformatf("got %b need 1", underflow_err));
    repeat (3) idle();
    @(negedge clk);
    check("underflow_sticky", underflow_err === 1'b1, $sformatf("got %b need 1", underflow_err));

    // Random traffic: gaps, occasional flush, random consumer.
    do_reset();
    base = commits;
    max_used = 0;
    n = 0;
    while (commits - base < 10 && n < 3000) begin
      @(posedge clk); #1;
      s_valid   = ($urandom_range(0, 99) < 70);
      s_sample  = SW'($urandom);
      flush     = ($urandom_range(0, 99) < 5);
      read_done = ($urandom_range(0, 99) < 30);
      @(negedge clk);
      n++;
    end
    check("random_commits", commits - base >= 10,
          $sformatf("got %0d commits in %0d cycles need 10", commits - base, n));
    repeat (10) idle();
    check("max_used", max_used <= FD, $sformatf("got max %0d need <= %0d", max_used, FD));
    check("drain", exp_q.size() == 0, $sformatf("got %0d writes outstanding need 0", exp_q.size()));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
